// File: rtl/prefetch_queue.sv
// prefetch_queue: 8086-style instruction prefetcher. It runs one byte read
// at a time on the shared bus at CS*16 + fetch_ip and buffers the returned
// bytes in a DEPTH-entry circular FIFO feeding the decoder. A flush empties
// the queue and restarts fetching at a new IP.
module prefetch_queue #(
   parameter int DEPTH  = 6,
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [15:0]                  CS,
   input  logic [15:0]                  IP_load,
   input  logic                         flush,
   input  logic                         bus_gnt,
   input  logic                         bus_ready,
   input  logic [DATA_W-1:0]            bus_data,
   output logic                         bus_req,
   output logic                         bus_rd,
   output logic [ADDR_W-1:0]            bus_addr,
   output logic [DATA_W-1:0]            q_data,
   output logic                         q_valid,
   input  logic                         q_pop,
   output logic [$clog2(DEPTH+1)-1:0]   q_count,
   output logic [15:0]                  fetch_ip
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t                         state;
   logic [PW-1:0]                  rd_ptr, wr_ptr;
   logic [CW-1:0]                  count;
   logic [DEPTH-1:0][DATA_W-1:0]   mem;
   logic [19:0]                    phys;
   logic                           wr_en, pop_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Flush outranks both the bus write and the pop; a flushed-away fetch is
   // dropped even when its data arrives in the same cycle.
   assign wr_en  = (state == S_WAIT) && bus_ready && !flush;
   assign pop_en = q_pop && (count != '0) && !flush;

   // Physical address wraps at 1MB, so the segment add is kept to 20 bits.
   assign phys = {CS, 4'b0000} + {4'b0000, fetch_ip};

   // Moore bus outputs decoded from the FSM state.
   always_comb begin
      bus_req  = 1'b0;
      bus_rd   = 1'b0;
      bus_addr = '0;
      if (state != S_IDLE) begin
         bus_req  = 1'b1;
         bus_rd   = 1'b1;
         bus_addr = phys[ADDR_W-1:0];
      end
   end

   assign q_data  = mem[rd_ptr];
   assign q_valid = (count != '0);
   assign q_count = count;

   // Fetch FSM plus queue pointers, occupancy and fetch IP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_ip <= 16'h0000;
      end else if (flush) begin
         state    <= S_IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_ip <= IP_load;
      end else begin
         case (state)
            S_IDLE:  if (count < FULL) state <= S_REQ;
            S_REQ:   if (bus_gnt) state <= S_WAIT;
            S_WAIT:  if (bus_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (wr_en) begin
            wr_ptr   <= ptr_inc(wr_ptr);
            fetch_ip <= fetch_ip + 16'd1;
         end
         if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
         // Only one fetch is ever outstanding and it starts below full, so
         // the increment can never overflow.
         case ({wr_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Queue storage, written when the bus returns read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     mem         <= '0;
      else if (wr_en) mem[wr_ptr] <= bus_data;
   end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue. The memory model returns addr[7:0];
// expected head bytes go into a scoreboard queue that a negedge monitor
// drains whenever the decoder side pops a valid byte.
module tb_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] CS, IP_load, fetch_ip;
   logic        flush, bus_gnt, bus_ready, q_pop;
   logic [7:0]  bus_data, q_data;
   logic        bus_req, bus_rd, q_valid;
   logic [19:0] bus_addr;
   logic [2:0]  q_count;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   prefetch_queue #(.DEPTH(6), .ADDR_W(20), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .CS(CS), .IP_load(IP_load), .flush(flush),
      .bus_gnt(bus_gnt), .bus_ready(bus_ready), .bus_data(bus_data),
      .bus_req(bus_req), .bus_rd(bus_rd), .bus_addr(bus_addr),
      .q_data(q_data), .q_valid(q_valid), .q_pop(q_pop),
      .q_count(q_count), .fetch_ip(fetch_ip)
   );

   always #5 clk = ~clk;

   // Memory answers every read with the low byte of its address.
   assign bus_data = bus_addr[7:0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every accepted pop must present the next expected byte.
   always @(negedge clk) begin
      if (reset && q_pop && q_valid && !flush) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 32'(q_data), 32'hxx);
         else chk("pop_data", 32'(q_data), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // 1. reset with random inputs
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         CS = 16'($urandom); IP_load = 16'($urandom); flush = 1'($urandom);
         bus_gnt = 1'($urandom); bus_ready = 1'($urandom); q_pop = 1'($urandom);
         #7;
      end
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_bus_rd", 32'(bus_rd), 0);
      chk("rst_bus_addr", 32'(bus_addr), 0);
      chk("rst_q_valid", 32'(q_valid), 0);
      chk("rst_q_count", 32'(q_count), 0);
      chk("rst_fetch_ip", 32'(fetch_ip), 0);
      chk("rst_q_data", 32'(q_data), 0);
      CS = 16'h1000; IP_load = 16'h0000; flush = 1'b0;
      bus_gnt = 1'b1; bus_ready = 1'b1; q_pop = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("c1_bus_req", 32'(bus_req), 1);
      chk("c1_bus_addr", 32'(bus_addr), 32'h10000);
      chk("c1_q_valid", 32'(q_valid), 0);
      tick();
      chk("c2_q_valid", 32'(q_valid), 0);
      tick();
      chk("c3_q_valid", 32'(q_valid), 1);
      chk("c3_fetch_ip", 32'(fetch_ip), 1);

      // 2. flush to 0x0010 and fill to full
      flush = 1'b1; IP_load = 16'h0010;
      tick();
      flush = 1'b0;
      chk("fl_q_count", 32'(q_count), 0);
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back(8'h10 + 8'(k));
         tick();
         chk("fill_addr", 32'(bus_addr), 32'h10010 + k);
         tick();
         tick();
      end
      chk("full_q_count", 32'(q_count), 6);
      chk("full_fetch_ip", 32'(fetch_ip), 32'h0016);
      tick();
      tick();
      chk("full_bus_req", 32'(bus_req), 0);

      // 3. pop ordering from full, bus stalled so no refill lands
      bus_gnt = 1'b0; bus_ready = 1'b0; q_pop = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) chk("refetch_not_yet", 32'(bus_req), 0);
         if (i == 1) chk("refetch_started", 32'(bus_req), 1);
      end
      q_pop = 1'b0;
      chk("empty_q_valid", 32'(q_valid), 0);
      chk("empty_q_count", 32'(q_count), 0);

      // 4. simultaneous pop and write at count 3
      bus_gnt = 1'b1; bus_ready = 1'b1;
      exp_q.push_back(8'h16); exp_q.push_back(8'h17); exp_q.push_back(8'h18);
      begin : wait3
         for (int i = 0; i < 50; i++) begin
            tick();
            if (q_count == 3'd3) disable wait3;
         end
         chk("wait_count3_timeout", 32'(q_count), 3);
      end
      tick();
      tick();
      chk("sim_in_wait", 32'(bus_rd), 1);
      q_pop = 1'b1;
      exp_q.push_back(8'h19);
      tick();
      q_pop = 1'b0; bus_gnt = 1'b0;
      chk("sim_q_count", 32'(q_count), 3);
      chk("sim_head", 32'(q_data), 32'h17);
      chk("sim_fetch_ip", 32'(fetch_ip), 32'h001A);

      // 5. flush in the same cycle as bus_ready during WAIT
      tick();
      bus_gnt = 1'b1; bus_ready = 1'b0;
      tick();
      chk("w5_addr", 32'(bus_addr), 32'h1001A);
      flush = 1'b1; IP_load = 16'h0200; bus_ready = 1'b1;
      exp_q.delete();
      tick();
      flush = 1'b0;
      chk("fw_q_count", 32'(q_count), 0);
      chk("fw_q_valid", 32'(q_valid), 0);
      chk("fw_fetch_ip", 32'(fetch_ip), 32'h0200);
      chk("fw_bus_req", 32'(bus_req), 0);
      exp_q.push_back(8'h00);
      tick();
      chk("fw_next_addr", 32'(bus_addr), 32'h10200);
      tick();
      tick();
      chk("fw_q_data", 32'(q_data), 0);
      chk("fw_q_count1", 32'(q_count), 1);
      bus_gnt = 1'b0; q_pop = 1'b1;
      tick();
      q_pop = 1'b0;
      chk("fw_drained", 32'(q_valid), 0);

      // 6. 1MB address wrap, fetch_ip wrap, grant stall, reset mid-WAIT
      CS = 16'hFFFF; flush = 1'b1; IP_load = 16'hFFFF;
      exp_q.delete();
      tick();
      flush = 1'b0; bus_gnt = 1'b1; bus_ready = 1'b1;
      exp_q.push_back(8'hEF);
      tick();
      chk("wrap_addr0", 32'(bus_addr), 32'h0FFEF);
      tick();
      tick();
      chk("wrap_fetch_ip", 32'(fetch_ip), 0);
      chk("wrap_q_data", 32'(q_data), 32'hEF);
      bus_gnt = 1'b0;
      tick();
      chk("wrap_addr1", 32'(bus_addr), 32'hFFFF0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_req", 32'(bus_req), 1);
         chk("stall_addr", 32'(bus_addr), 32'hFFFF0);
      end
      bus_gnt = 1'b1; bus_ready = 1'b0;
      tick();
      chk("mid_wait_rd", 32'(bus_rd), 1);
      #2 reset = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_bus_req", 32'(bus_req), 0);
      chk("arst_bus_rd", 32'(bus_rd), 0);
      chk("arst_bus_addr", 32'(bus_addr), 0);
      chk("arst_q_valid", 32'(q_valid), 0);
      chk("arst_q_count", 32'(q_count), 0);
      chk("arst_fetch_ip", 32'(fetch_ip), 0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
